sdram_arb_rr: RTL
=================

# sdram_arb_rr

Parametrised N-channel arbiter for the SDRAM controller. It sits between the NCH user request ports and the shared command engine, and serialises read/write bursts and auto-refresh onto that single engine. Auto-refresh has fixed top priority. User channels are served round-robin, and every grant is announced with a one-cycle acknowledge pulse. It replaces the fixed write/read/refresh arbiter and generalises it to any channel count, with fair scheduling and an optional hang watchdog.

## Interface

Parameters:
- NCH, 4, number of user request channels (2..16)
- CW, $clog2(NCH), width of the channel index
- TO_CYC, 1024, watchdog limit in sclk cycles (used only with SDRAM_ARB_WDOG_EN)

Ports:
- sclk  in  1  clock; all logic is on the rising edge
- srst_n  in  1  reset; asynchronous, active-low
- init_end  in  1  SDRAM init-sequence complete; sticky once seen high
- req  in  NCH  per-channel request level; held high until the matching ack
- aref_req  in  1  refresh request level; held high until aref_ack
- op_done  in  1  one-cycle pulse from the command engine: current operation finished
- grant  out  NCH  one-hot, registered; high for the whole granted operation
- ack  out  NCH  one-cycle pulse on the first cycle of the matching grant bit
- aref_grant  out  1  registered; high for the whole refresh operation
- aref_ack  out  1  one-cycle pulse on the first cycle of aref_grant
- cur_ch  out  CW  index of the granted channel; holds its last value otherwise
- busy  out  1  high when the state is GRANT or AREF
- wdog_err  out  1  one-cycle timeout pulse (tied 0 without the macro)

## Operation

- States: WAIT_INIT, IDLE, GRANT, AREF.
- WAIT_INIT -> IDLE on the cycle after init_end is sampled high. No request is seen before that.
- IDLE -> AREF if aref_req=1. This holds regardless of req.
- IDLE -> GRANT if aref_req=0 and req!=0.
  - The winner is the first set bit of req, searching upward from ptr and wrapping NCH-1 -> 0.
  - ptr is then loaded with winner+1, mod NCH.
- GRANT -> IDLE and AREF -> IDLE on op_done=1.
- Any other cycle holds the current state.
- A refresh pending during GRANT is served at the next IDLE, ahead of all channels.
- op_done seen in WAIT_INIT or IDLE is ignored.
- req and aref_req are not consumed; each is released by its requester after the ack.
  - Holding req high after ack causes a re-request once the rotation comes back.
- ptr resets to 0. Only a channel grant advances it; refresh does not.
- After reset every output is 0, including cur_ch and wdog_err. State is WAIT_INIT. ptr and the init_end latch are cleared.
- Reset asserted mid-operation drops grant/aref_grant immediately (asynchronous clear). No completion is reported.

## Timing

- A request sampled in IDLE at edge t gives grant/aref_grant and ack/aref_ack high after edge t+1.
- ack is low from t+2 onward.
- op_done sampled high at edge t drops grant after edge t+1, when the state becomes IDLE.
- The earliest next grant is after edge t+2, so there is at least one IDLE cycle between operations.
- Worst-case wait for a continuously requesting channel is NCH-1 channel operations plus any refreshes that come in.
- grant, aref_grant and busy are mutually consistent in every cycle.
- At most one bit of grant plus aref_grant is high at any time.

## Configuration

- SDRAM_ARB_WDOG_EN defined:
  - A counter runs while busy and clears on entry to GRANT or AREF.
  - If it reaches TO_CYC-1 without op_done, the state forces to IDLE and wdog_err pulses for one cycle.
  - The grant drops on that same edge and ptr keeps its value.
- SDRAM_ARB_WDOG_EN not defined:
  - No counter is built.
  - wdog_err is constant 0.
  - GRANT/AREF wait for op_done indefinitely.

## Test plan

- Reset release, init_end=0 for 20 cycles, req=4'b1111 -> grant stays 0. init_end=1 -> ch0 is granted 2 cycles later with ack[0] as a 1-cycle pulse.
- NCH=4, req=4'b1111 held, op_done 5 cycles after each grant -> grant order is 0,1,2,3,0 and each is preceded by exactly one IDLE cycle.
- In IDLE, aref_req=1 and req=4'b0100 in the same cycle -> aref_grant/aref_ack first. After op_done, ch2 is granted and ptr is unaffected by the refresh.
- During a ch1 grant, assert aref_req and req[3] -> after op_done, refresh comes next, then ch3. op_done pulsed in IDLE changes nothing.
- With SDRAM_ARB_WDOG_EN and TO_CYC=16, grant ch0 and withhold op_done -> after 16 busy cycles wdog_err pulses once, grant drops, and ch1 is granted next if requested.
- Drive srst_n low during GRANT on ch2 -> all outputs 0 immediately. After release, re-init is required and the first winner is ch0.

Source files
------------

// File: rtl/sdram_arb_rr.sv
// Round-robin SDRAM command arbiter: NCH user channels plus top-priority auto-refresh.
// Optional hang watchdog enabled by defining SDRAM_ARB_WDOG_EN.
module sdram_arb_rr #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned CW     = $clog2(NCH),
   parameter int unsigned TO_CYC = 1024
) (
   input  logic           sclk,
   input  logic           srst_n,
   input  logic           init_end,
   input  logic [NCH-1:0] req,
   input  logic           aref_req,
   input  logic           op_done,
   output logic [NCH-1:0] grant,
   output logic [NCH-1:0] ack,
   output logic           aref_grant,
   output logic           aref_ack,
   output logic [CW-1:0]  cur_ch,
   output logic           busy,
   output logic           wdog_err
);

   typedef enum logic [1:0] {WAIT_INIT, IDLE, GRANT, AREF} state_t;

   state_t           state_q, state_d;
   logic             init_q;
   logic [CW-1:0]    ptr_q, ptr_d;
   logic [NCH-1:0]   grant_d, ack_d;
   logic             aref_grant_d, aref_ack_d, busy_d, wdog_d;
   logic [CW-1:0]    cur_ch_d;
   logic             init_ok_c;
   logic             win_vld_c;
   logic [CW-1:0]    win_c;
   int unsigned      idx;

   assign init_ok_c = init_end | init_q;

   // First requesting channel at or above ptr, wrapping NCH-1 -> 0
   always_comb begin
      win_vld_c = 1'b0;
      win_c     = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NCH; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (!win_vld_c && req[CW'(idx)]) begin
            win_vld_c = 1'b1;
            win_c     = CW'(idx);
         end
      end
   end

`ifdef SDRAM_ARB_WDOG_EN
   localparam int unsigned TW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          wd_hit_c;

   assign wd_hit_c = (cnt_q == TW'(TO_CYC - 1));
`endif

   // Next state and next registered outputs
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_d      = grant;
      ack_d        = '0;
      aref_grant_d = aref_grant;
      aref_ack_d   = 1'b0;
      cur_ch_d     = cur_ch;
      wdog_d       = 1'b0;
      case (state_q)
         WAIT_INIT: begin
            if (init_ok_c) state_d = IDLE;
         end
         IDLE: begin
            if (aref_req) begin
               state_d      = AREF;
               aref_grant_d = 1'b1;
               aref_ack_d   = 1'b1;
            end else if (win_vld_c) begin
               state_d  = GRANT;
               grant_d  = NCH'(1) << win_c;
               ack_d    = NCH'(1) << win_c;
               cur_ch_d = win_c;
               ptr_d    = (win_c == CW'(NCH - 1)) ? '0 : win_c + CW'(1);
            end
         end
         GRANT, AREF: begin
            if (op_done) begin
               state_d      = IDLE;
               grant_d      = '0;
               aref_grant_d = 1'b0;
            end
`ifdef SDRAM_ARB_WDOG_EN
            else if (wd_hit_c) begin
               state_d      = IDLE;
               grant_d      = '0;
               aref_grant_d = 1'b0;
               wdog_d       = 1'b1;
            end
`endif
         end
         default: state_d = WAIT_INIT;
      endcase
      busy_d = (state_d == GRANT) || (state_d == AREF);
   end

`ifdef SDRAM_ARB_WDOG_EN
   // Counts cycles spent in one operation; zero on entry
   always_comb begin
      cnt_d = '0;
      if (busy_d && (state_d == state_q)) cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`endif

   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         state_q    <= WAIT_INIT;
         init_q     <= 1'b0;
         ptr_q      <= '0;
         grant      <= '0;
         ack        <= '0;
         aref_grant <= 1'b0;
         aref_ack   <= 1'b0;
         cur_ch     <= '0;
         busy       <= 1'b0;
         wdog_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_q     <= init_ok_c;
         ptr_q      <= ptr_d;
         grant      <= grant_d;
         ack        <= ack_d;
         aref_grant <= aref_grant_d;
         aref_ack   <= aref_ack_d;
         cur_ch     <= cur_ch_d;
         busy       <= busy_d;
         wdog_err   <= wdog_d;
      end
   end

endmodule
